// File: rtl/cla_pipe_addsub_if.sv
// Stream interface for cla_pipe_addsub: operand beat in, result beat out, valid/ready on both sides.
interface cla_pipe_addsub_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group is resolved per stage,
// with a single global advance enable so the whole pipe stalls together.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int unsigned LAT = WIDTH / 4;

    logic             adv;
    logic             out_valid_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_q;

    assign adv           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int unsigned LO = 4 * k;

        logic             v_q;
        // {resolved sum bits LO-1..0, carry into group k}
        logic [LO:0]      cs_q;
        logic [WIDTH-1:LO] a_q;
        logic [WIDTH-1:LO] bp_q;

        logic [3:0]       p;
        logic [3:0]       g;
        logic [3:0]       s;
        logic [4:0]       c;
        logic [LO+4:0]    nxt_cs;

        if (k == 0) begin : g_load
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    cs_q <= '0;
                    a_q  <= '0;
                    bp_q <= '0;
                end else if (adv) begin
                    v_q  <= bus.in_valid;
                    cs_q <= bus.cin ^ bus.sub;
                    a_q  <= bus.a;
                    bp_q <= bus.b ^ {WIDTH{bus.sub}};
                end
            end
        end else begin : g_load
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    cs_q <= '0;
                    a_q  <= '0;
                    bp_q <= '0;
                end else if (adv) begin
                    v_q  <= g_stage[k-1].v_q;
                    cs_q <= g_stage[k-1].nxt_cs;
                    a_q  <= g_stage[k-1].a_q[WIDTH-1:LO];
                    bp_q <= g_stage[k-1].bp_q[WIDTH-1:LO];
                end
            end
        end

        always_comb begin
            p    = a_q[LO+3:LO] ^ bp_q[LO+3:LO];
            g    = a_q[LO+3:LO] & bp_q[LO+3:LO];
            c[0] = cs_q[0];
            c[1] = g[0] | (p[0] & c[0]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c[0]);
            s    = p ^ c[3:0];
            // Append this group's sum bits; the consumed carry slot takes the group carry-out.
            nxt_cs    = {s, cs_q};
            nxt_cs[0] = c[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= g_stage[LAT-1].v_q;
            sum_q       <= g_stage[LAT-1].nxt_cs[WIDTH:1];
            cout_q      <= g_stage[LAT-1].nxt_cs[0];
            ovf_q       <= g_stage[LAT-1].c[3] ^ g_stage[LAT-1].c[4];
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and random checks of cla_pipe_addsub at WIDTH = 4, 16 and 32.
module tb_cla_pipe_addsub;
    localparam int NRAND   = 10000;
    localparam int RBUDGET = 40000;

    logic clk = 1'b0;
    logic rst;
    int   nassert = 0;
    int   nfail   = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(4))  bus4 ();
    cla_pipe_addsub_if #(.WIDTH(16)) bus16 ();
    cla_pipe_addsub_if #(.WIDTH(32)) bus32 ();

    cla_pipe_addsub #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    cla_pipe_addsub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_pipe_addsub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    // Behavioural reference: {ovf, cout, sum} from true integer/signed arithmetic.
    function automatic logic [33:0] model(int w, longint a, longint b, logic cin, logic sub);
        longint m, h, sa, sb, ur, sr;
        logic   co, ov;
        m  = longint'(1) << w;
        h  = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (sub) begin
            ur = a - b - longint'(cin);
            sr = sa - sb - longint'(cin);
            co = (ur >= 0);
        end else begin
            ur = a + b + longint'(cin);
            sr = sa + sb + longint'(cin);
            co = (ur >= m);
        end
        ur = (ur + m) % m;
        ov = (sr < -h) || (sr >= h);
        return {ov, co, ur[31:0]};
    endfunction

    task automatic test_reset();
        #1;
        nassert++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.cout !== 1'b0 ||
            bus16.ovf !== 1'b0) begin
            nfail++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b, required 0/0000/0/0",
                     bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
        end
        nassert++;
        if (bus16.in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus16.in_ready);
        end
        nassert++;
        if (bus4.out_valid !== 1'b0 || bus32.out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_other_widths: got v4=%b v32=%b, required 0/0",
                     bus4.out_valid, bus32.out_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [15:0] va [8] = '{16'hFFFF, 16'h1234, 16'h0005, 16'h0009,
                                16'h7FFF, 16'h8000, 16'h8000, 16'h0000};
        logic [15:0] vb [8] = '{16'h0001, 16'h4321, 16'h0007, 16'h0002,
                                16'h0001, 16'h0001, 16'h8000, 16'h0000};
        logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        // {ovf, cout, sum}
        logic [17:0] ve [8] = '{{2'b01, 16'h0000}, {2'b00, 16'h5556}, {2'b00, 16'hFFFE},
                                {2'b01, 16'h0006}, {2'b10, 16'h8000}, {2'b11, 16'h7FFF},
                                {2'b11, 16'h0000}, {2'b01, 16'h0000}};
        logic [17:0] o;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            bus16.in_valid  = 1'b1;
            bus16.a         = va[n];
            bus16.b         = vb[n];
            bus16.cin       = vc[n];
            bus16.sub       = vs[n];
            bus16.out_ready = 1'b1;
            #1;
            nassert++;
            if (bus16.in_ready !== 1'b1) begin
                nfail++;
                $display("FAIL arith%0d_in_ready: got %b, required 1", n, bus16.in_ready);
            end
            for (int i = 0; i <= 4; i++) begin
                @(negedge clk);
                if (i == 0) bus16.in_valid = 1'b0;
                #1;
                o = {bus16.ovf, bus16.cout, bus16.sum};
                nassert++;
                if (i < 4) begin
                    if (bus16.out_valid !== 1'b0) begin
                        nfail++;
                        $display("FAIL arith%0d_latency: out_valid=%b after edge +%0d, required 0",
                                 n, bus16.out_valid, i);
                    end
                end else if (bus16.out_valid !== 1'b1 || o !== ve[n]) begin
                    nfail++;
                    $display("FAIL arith%0d_result: got v=%b {ovf,cout,sum}=%h, required 1 %h",
                             n, bus16.out_valid, o, ve[n]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [6] = '{16'h0001, 16'h00FF, 16'h0010, 16'hFFFF, 16'h0000, 16'h4000};
        logic [15:0] vb [6] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h4000};
        logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [17:0] ve [6] = '{{2'b00, 16'h0003}, {2'b00, 16'h0100}, {2'b01, 16'h000F},
                                {2'b01, 16'hFFFF}, {2'b00, 16'hFFFF}, {2'b10, 16'h8000}};
        int          sent  = 0;
        int          got   = 0;
        int          stall = 0;
        int          cyc   = 0;
        bit          first = 1'b0;
        logic [17:0] o;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus16.out_valid && !first) begin
                first = 1'b1;
                stall = 3;
            end
            bus16.out_ready = (stall == 0);
            if (stall > 0) stall--;
            bus16.in_valid = (sent < 6);
            if (sent < 6) begin
                bus16.a   = va[sent];
                bus16.b   = vb[sent];
                bus16.cin = vc[sent];
                bus16.sub = vs[sent];
            end
            #1;
            o = {bus16.ovf, bus16.cout, bus16.sum};
            if (!bus16.out_ready) begin
                nassert++;
                if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 || o !== ve[got]) begin
                    nfail++;
                    $display("FAIL b2b_stall: got rdy=%b v=%b out=%h, required 0 1 %h",
                             bus16.in_ready, bus16.out_valid, o, ve[got]);
                end
            end else if (got > 0) begin
                nassert++;
                if (bus16.out_valid !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b_rate: got out_valid=%b before beat %0d, required 1",
                             bus16.out_valid, got);
                end
            end
            if (bus16.in_valid && bus16.in_ready) sent++;
            if (bus16.out_valid && bus16.out_ready) begin
                nassert++;
                if (o !== ve[got]) begin
                    nfail++;
                    $display("FAIL b2b_beat%0d: got %h, required %h", got, o, ve[got]);
                end
                got++;
            end
        end
        bus16.in_valid = 1'b0;
        nassert++;
        if (got != 6) begin
            nfail++;
            $display("FAIL b2b_count: got %0d beats, required 6", got);
        end
    endtask

    task automatic test_reset_inflight();
        int cyc = 0;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a        = 16'(16'h1111 * (i + 1));
            bus16.b        = 16'h2222;
            bus16.cin      = 1'b0;
            bus16.sub      = 1'b0;
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        nassert++;
        if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'h3333 || bus16.in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL rst_pre: got v=%b sum=%h rdy=%b, required 1 3333 0",
                     bus16.out_valid, bus16.sum, bus16.in_ready);
        end
        rst = 1'b1;
        #1;
        nassert++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.cout !== 1'b0 ||
            bus16.ovf !== 1'b0 || bus16.in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_async: got v=%b sum=%h c=%b o=%b rdy=%b, required 0 0000 0 0 1",
                     bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf, bus16.in_ready);
        end
        @(negedge clk);
        rst             = 1'b0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            nassert++;
            if (bus16.out_valid !== 1'b0) begin
                nfail++;
                $display("FAIL rst_stale: got out_valid=%b %0d cycles after release, required 0",
                         bus16.out_valid, i + 1);
            end
        end
    endtask

    task automatic test_random();
        fork
            begin : g_r4
                int          acc = 0, got = 0, cyc = 0;
                bit          pend = 1'b0;
                logic [33:0] e, o;
                logic [33:0] q [$];
                while (got < NRAND && cyc < RBUDGET) begin
                    @(negedge clk);
                    cyc++;
                    if (!pend) begin
                        bus4.in_valid = (acc < NRAND) && ($urandom_range(3) != 0);
                        bus4.a        = 4'($urandom);
                        bus4.b        = 4'($urandom);
                        bus4.cin      = 1'($urandom);
                        bus4.sub      = 1'($urandom);
                    end
                    bus4.out_ready = ($urandom_range(3) != 0);
                    #1;
                    pend = bus4.in_valid && !bus4.in_ready;
                    if (bus4.in_valid && bus4.in_ready) begin
                        q.push_back(model(4, longint'(bus4.a), longint'(bus4.b), bus4.cin,
                                          bus4.sub));
                        acc++;
                    end
                    if (bus4.out_valid && bus4.out_ready) begin
                        nassert++;
                        o = {bus4.ovf, bus4.cout, 32'(bus4.sum)};
                        if (q.size() == 0) begin
                            nfail++;
                            $display("FAIL rand_w4: got beat %h, required none", o);
                        end else begin
                            e = q.pop_front();
                            if (o !== e) begin
                                nfail++;
                                $display("FAIL rand_w4 beat %0d: got %h, required %h", got, o, e);
                            end
                        end
                        got++;
                    end
                end
                bus4.in_valid = 1'b0;
                nassert++;
                if (got != NRAND || q.size() != 0) begin
                    nfail++;
                    $display("FAIL rand_w4_count: got %0d beats (%0d queued), required %0d",
                             got, q.size(), NRAND);
                end
            end
            begin : g_r16
                int          acc = 0, got = 0, cyc = 0;
                bit          pend = 1'b0;
                logic [33:0] e, o;
                logic [33:0] q [$];
                while (got < NRAND && cyc < RBUDGET) begin
                    @(negedge clk);
                    cyc++;
                    if (!pend) begin
                        bus16.in_valid = (acc < NRAND) && ($urandom_range(3) != 0);
                        bus16.a        = 16'($urandom);
                        bus16.b        = 16'($urandom);
                        bus16.cin      = 1'($urandom);
                        bus16.sub      = 1'($urandom);
                    end
                    bus16.out_ready = ($urandom_range(3) != 0);
                    #1;
                    pend = bus16.in_valid && !bus16.in_ready;
                    if (bus16.in_valid && bus16.in_ready) begin
                        q.push_back(model(16, longint'(bus16.a), longint'(bus16.b), bus16.cin,
                                          bus16.sub));
                        acc++;
                    end
                    if (bus16.out_valid && bus16.out_ready) begin
                        nassert++;
                        o = {bus16.ovf, bus16.cout, 32'(bus16.sum)};
                        if (q.size() == 0) begin
                            nfail++;
                            $display("FAIL rand_w16: got beat %h, required none", o);
                        end else begin
                            e = q.pop_front();
                            if (o !== e) begin
                                nfail++;
                                $display("FAIL rand_w16 beat %0d: got %h, required %h", got, o, e);
                            end
                        end
                        got++;
                    end
                end
                bus16.in_valid = 1'b0;
                nassert++;
                if (got != NRAND || q.size() != 0) begin
                    nfail++;
                    $display("FAIL rand_w16_count: got %0d beats (%0d queued), required %0d",
                             got, q.size(), NRAND);
                end
            end
            begin : g_r32
                int          acc = 0, got = 0, cyc = 0;
                bit          pend = 1'b0;
                logic [33:0] e, o;
                logic [33:0] q [$];
                while (got < NRAND && cyc < RBUDGET) begin
                    @(negedge clk);
                    cyc++;
                    if (!pend) begin
                        bus32.in_valid = (acc < NRAND) && ($urandom_range(3) != 0);
                        bus32.a        = 32'($urandom);
                        bus32.b        = 32'($urandom);
                        bus32.cin      = 1'($urandom);
                        bus32.sub      = 1'($urandom);
                    end
                    bus32.out_ready = ($urandom_range(3) != 0);
                    #1;
                    pend = bus32.in_valid && !bus32.in_ready;
                    if (bus32.in_valid && bus32.in_ready) begin
                        q.push_back(model(32, longint'(bus32.a), longint'(bus32.b), bus32.cin,
                                          bus32.sub));
                        acc++;
                    end
                    if (bus32.out_valid && bus32.out_ready) begin
                        nassert++;
                        o = {bus32.ovf, bus32.cout, bus32.sum};
                        if (q.size() == 0) begin
                            nfail++;
                            $display("FAIL rand_w32: got beat %h, required none", o);
                        end else begin
                            e = q.pop_front();
                            if (o !== e) begin
                                nfail++;
                                $display("FAIL rand_w32 beat %0d: got %h, required %h", got, o, e);
                            end
                        end
                        got++;
                    end
                end
                bus32.in_valid = 1'b0;
                nassert++;
                if (got != NRAND || q.size() != 0) begin
                    nfail++;
                    $display("FAIL rand_w32_count: got %0d beats (%0d queued), required %0d",
                             got, q.size(), NRAND);
                end
            end
        join
    endtask

    initial begin
        rst             = 1'b1;
        bus4.in_valid   = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.sub  = 1'b0;
        bus16.in_valid  = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus32.in_valid  = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
        bus4.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        bus32.out_ready = 1'b1;

        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_inflight();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. It is the multi-group successor of the team's single-cycle 4-bit CLA. The operand is split into 4-bit lookahead groups, and one group is resolved per pipeline stage. It adds subtract mode, signed-overflow detection and a valid/ready stream handshake on both sides, so wide adders close timing at full clock rate inside the datapath.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- LAT (derived, localparam), WIDTH/4, pipeline depth in cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of bit WIDTH-1.
- ovf  out  1  signed overflow.

## Operation
- Accept: a beat is accepted on a rising edge where in_valid & in_ready.
- Add (sub=0): {cout,sum} = a + b + cin.
- Subtract (sub=1): internal B' = ~b and carry-in c0 = ~cin. Result is sum = a - b - cin (mod 2^WIDTH).
- Subtract cout: raw adder carry, so 1 = no borrow, 0 = borrow.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is valid in both modes.
- Group k (k = 0..LAT-1) covers bits 4k+3..4k.
- Group logic per stage: P = a^B' and G = a&B' for the group; the four internal carries and the group carry-out come from full 4-bit lookahead equations, not a ripple chain.
- Stage k resolves group k using the carry registered by stage k-1. Stage 0 uses c0.
- Higher-group operand bits travel through skew registers until their stage.
- Resolved lower sum bits travel forward with the beat.
- The final stage drives sum/cout/ovf directly from registers. There is no combinational path from a/b to the outputs.
- Each stage has a valid bit; out_valid is the last stage's valid.
- Pipeline enable: adv = out_ready | ~out_valid.
- in_ready = adv. This is combinational from out_ready and out_valid only, never from in_valid.
- When adv = 1, every stage loads from its predecessor. Stage 0 loads the input beat, and its valid = in_valid.
- When adv = 0, all stage registers and outputs hold. Beats are never dropped, duplicated or reordered.
- Bubbles are carried through the pipeline as invalid stages (no bubble collapse).
- Throughput: one beat per cycle while out_ready = 1.

## Timing
- Reset (asynchronous assert): all stage valids = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0.
- Reset datapath registers clear to 0.
- in_ready = 1 during and after reset, because out_valid = 0.
- Reset deassertion is used synchronously; the first beat can be accepted on the first edge after release.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+LAT, provided no stall occurs. For WIDTH=16, LAT=4.
- Stall: while out_valid & ~out_ready, sum/cout/ovf/out_valid are stable and in_ready = 0.
- The output beat completes on the edge where out_valid & out_ready; a new beat can enter the pipe on that same edge.
- Reset mid-operation: all in-flight beats are discarded. No result from a pre-reset beat ever appears.
- in_valid with in_ready = 0: the beat is not taken, and the source must hold it.
- Carry wrap: a carry out of the MSB appears only on cout; sum wraps modulo 2^WIDTH.

## Test plan
- WIDTH=16, add a=0xFFFF b=0x0001 cin=0 -> after 4 cycles: sum=0x0000, cout=1, ovf=0. Also check a=0x1234 b=0x4321 cin=1 -> sum=0x5556, cout=0.
- Subtract a=0x0005 b=0x0007 cin=0 -> sum=0xFFFE, cout=0, ovf=0. Also check a=0x0009 b=0x0002 cin=1 -> sum=0x0006, cout=1.
- Overflow: add 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Back-to-back: 6 beats on consecutive cycles; out_ready=0 for 3 cycles when the first result arrives.
  - Required: outputs held stable and in_ready=0 during the stall.
  - Required: all 6 results emerge in order, none lost or duplicated.
  - Required: with out_ready=1, one result per cycle.
- Reset with 3 beats in flight -> out_valid=0 and sum/cout/ovf=0 immediately (before the next edge); no stale beat appears after release.
- Random regression, 10k beats each at WIDTH=4, 16 and 32:
  - Stimulus: random a, b, cin, sub, in_valid and out_ready.
  - Required: every result matches a behavioural model (a±b±cin, cout, ovf) with exact ordering.
